uart_tx: RTL

//  Serial UART transmitter; the stage directly upstream of UartRx on the serial line.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM states, parity modes and small helpers.
// Used by uart_tx and reusable by the matching receiver.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-slot timer: counts 0..2*p_BITSLOT_HALF_PERIOD-1 while enabled and flags the wrap.
// A clear takes priority over counting and restarts the slot from zero.
module uart_bit_timer #(
  parameter int p_BITSLOT_HALF_PERIOD = 1,
  localparam int CW = $clog2(2 * p_BITSLOT_HALF_PERIOD)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] SLOT_LAST = CW'(2 * p_BITSLOT_HALF_PERIOD - 1);

  assign o_wrap = i_en && (o_cnt == SLOT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_clr || o_wrap) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop bits out.
// o_tx and o_ready are registered; o_ready also opens in the final stop clock for gapless frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int p_BITSLOT_HALF_PERIOD = 1,
  parameter int p_DATA_BITS           = 8,
  parameter int p_STOP_BITS           = 1,
  parameter int p_PARITY              = PARITY_NONE
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_DATA_BITS-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int CW = $clog2(2 * p_BITSLOT_HALF_PERIOD);
  localparam int BW = $clog2(max_int(p_DATA_BITS, p_STOP_BITS) + 1);

  localparam logic [CW-1:0] SLOT_PRE_LAST = CW'(2 * p_BITSLOT_HALF_PERIOD - 2);
  localparam logic [BW-1:0] DATA_LAST     = BW'(p_DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST     = BW'(p_STOP_BITS - 1);
  localparam logic          PAR_INVERT    = (p_PARITY == PARITY_ODD);

  uart_state_t            state;
  logic [p_DATA_BITS-1:0] shift;
  logic [BW-1:0]          bit_cnt;
  logic                   par_bit;
  logic [CW-1:0]          slot_cnt;
  logic                   slot_wrap;
  logic                   xfer;

  assign xfer   = i_valid && o_ready;
  assign o_busy = (state != ST_IDLE);

  uart_bit_timer #(
    .p_BITSLOT_HALF_PERIOD(p_BITSLOT_HALF_PERIOD)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (xfer),
    .i_en   (o_busy),
    .o_cnt  (slot_cnt),
    .o_wrap (slot_wrap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_tx    <= 1'b1;
      o_ready <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_tx    <= 1'b1;
          o_ready <= 1'b1;
          if (xfer) begin
            shift   <= i_data;
            par_bit <= (^i_data) ^ PAR_INVERT;
            bit_cnt <= '0;
            state   <= ST_START;
            o_tx    <= 1'b0;
            o_ready <= 1'b0;
          end
        end
        ST_START: begin
          if (slot_wrap) begin
            state   <= ST_DATA;
            o_tx    <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (slot_wrap) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (p_PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                o_tx  <= par_bit;
              end else begin
                state <= ST_STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              o_tx    <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (slot_wrap) begin
            state   <= ST_STOP;
            o_tx    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          // Registered ready: raise it one clock early so it is high during the last stop clock.
          if (bit_cnt == STOP_LAST && slot_cnt == SLOT_PRE_LAST && !slot_wrap)
            o_ready <= 1'b1;
          if (slot_wrap) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (xfer) begin
                shift   <= i_data;
                par_bit <= (^i_data) ^ PAR_INVERT;
                state   <= ST_START;
                o_tx    <= 1'b0;
              end else begin
                state   <= ST_IDLE;
                o_ready <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
